// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA/SVGA raster timing generator.
// Free-running horizontal/vertical counters with registered sync, blanking,
// data-enable, end-of-line and start-of-frame outputs. Every output is
// registered from the same next-state value, so all decodes line up with
// the hcount/vcount presented in the same cycle.
// Optional feature: define VGA_TIMING_GEN_FRAME_CNT_EN to add the frame_cnt
// output, a wrapping counter that advances on every start-of-frame.
// Reset is asynchronous and active-high. The integrator provides any
// reset-release synchronisation.

module vga_timing_gen #(
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               de,
    output logic               sof,
    output logic               eol
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int W1      = CNT_W + 1;

    // Decode thresholds carry one extra bit so that a sync window ending
    // exactly at 2^CNT_W does not alias back to zero.
    localparam logic [CNT_W:0] H_LAST     = W1'(H_TOTAL - 1);
    localparam logic [CNT_W:0] V_LAST     = W1'(V_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT_END  = W1'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT_END  = W1'(V_ACTIVE);
    localparam logic [CNT_W:0] H_SYNC_BEG = W1'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_SYNC_END = W1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_SYNC_BEG = W1'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_SYNC_END = W1'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    // Parameter sanity checks, evaluated at elaboration.
    if ((H_TOTAL - 1) > (2 ** CNT_W - 1)) begin : g_h_range_err
        $error("vga_timing_gen: H_TOTAL-1 (%0d) does not fit in CNT_W=%0d bits", H_TOTAL - 1, CNT_W);
    end
    if ((V_TOTAL - 1) > (2 ** CNT_W - 1)) begin : g_v_range_err
        $error("vga_timing_gen: V_TOTAL-1 (%0d) does not fit in CNT_W=%0d bits", V_TOTAL - 1, CNT_W);
    end
    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0)) begin : g_h_zero_err
        $error("vga_timing_gen: horizontal porch/sync parameters must be non-zero");
    end
    if ((V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_v_zero_err
        $error("vga_timing_gen: vertical porch/sync parameters must be non-zero");
    end
    if (FRAME_W < 1) begin : g_frame_w_err
        $error("vga_timing_gen: FRAME_W must be at least 1");
    end

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic [CNT_W:0]   h_ext;
    logic [CNT_W:0]   v_ext;

    // Next raster position; decodes below are taken from this value so the
    // registered outputs describe the registered position.
    always_comb begin
        h_wrap = ({1'b0, hcount} == H_LAST);
        v_wrap = ({1'b0, vcount} == V_LAST);
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + 1'b1;
        end
        h_ext = {1'b0, h_next};
        v_ext = {1'b0, v_next};
    end

    // Position counters and decoded timing outputs; all hold on stall except
    // sof, which is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= ~HS_ON;
            vsync  <= ~VS_ON;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
            de     <= 1'b1;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else if (en) begin
            hcount <= h_next;
            vcount <= v_next;
            hblnk  <= (h_ext >= H_ACT_END);
            vblnk  <= (v_ext >= V_ACT_END);
            de     <= (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
            hsync  <= ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HS_ON : ~HS_ON;
            vsync  <= ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? VS_ON : ~VS_ON;
            eol    <= (h_ext == H_LAST);
            sof    <= h_wrap && v_wrap;
        end else begin
            sof    <= 1'b0;
        end
    end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    // Frame counter advances on the same edge that raises sof.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule
